// File: rtl/axi_lite_arb_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter: round-robin grant taken in IDLE,
// one transaction in flight, all channel forwarding combinational from the granted master.
module axi_lite_arb_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0]   M0_AXI_AWADDR,
  input  logic [2:0]              M0_AXI_AWPROT,
  input  logic                    M0_AXI_AWVALID,
  output logic                    M0_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   M0_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M0_AXI_WSTRB,
  input  logic                    M0_AXI_WVALID,
  output logic                    M0_AXI_WREADY,
  output logic [1:0]              M0_AXI_BRESP,
  output logic                    M0_AXI_BVALID,
  input  logic                    M0_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   M0_AXI_ARADDR,
  input  logic [2:0]              M0_AXI_ARPROT,
  input  logic                    M0_AXI_ARVALID,
  output logic                    M0_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   M0_AXI_RDATA,
  output logic [1:0]              M0_AXI_RRESP,
  output logic                    M0_AXI_RVALID,
  input  logic                    M0_AXI_RREADY,
  // master 1 (load/store unit)
  input  logic [ADDR_WIDTH-1:0]   M1_AXI_AWADDR,
  input  logic [2:0]              M1_AXI_AWPROT,
  input  logic                    M1_AXI_AWVALID,
  output logic                    M1_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   M1_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M1_AXI_WSTRB,
  input  logic                    M1_AXI_WVALID,
  output logic                    M1_AXI_WREADY,
  output logic [1:0]              M1_AXI_BRESP,
  output logic                    M1_AXI_BVALID,
  input  logic                    M1_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   M1_AXI_ARADDR,
  input  logic [2:0]              M1_AXI_ARPROT,
  input  logic                    M1_AXI_ARVALID,
  output logic                    M1_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   M1_AXI_RDATA,
  output logic [1:0]              M1_AXI_RRESP,
  output logic                    M1_AXI_RVALID,
  input  logic                    M1_AXI_RREADY,
  // shared slave
  output logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  output logic [2:0]              S_AXI_AWPROT,
  output logic                    S_AXI_AWVALID,
  input  logic                    S_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                    S_AXI_WVALID,
  input  logic                    S_AXI_WREADY,
  input  logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_BVALID,
  output logic                    S_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  output logic [2:0]              S_AXI_ARPROT,
  output logic                    S_AXI_ARVALID,
  input  logic                    S_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  input  logic [1:0]              S_AXI_RRESP,
  input  logic                    S_AXI_RVALID,
  output logic                    S_AXI_RREADY,
  output logic [1:0]              arb_grant,
  output logic                    arb_busy
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP} state_t;

  logic [1:0][ADDR_WIDTH-1:0] awaddr, araddr;
  logic [1:0][2:0]            awprot, arprot;
  logic [1:0][DATA_WIDTH-1:0] wdata, rdata;
  logic [1:0][SW-1:0]         wstrb;
  logic [1:0][1:0]            rresp, bresp;
  logic [1:0] awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0] arvalid, arready, rvalid, rready;

  assign awaddr  = {M1_AXI_AWADDR,  M0_AXI_AWADDR};
  assign awprot  = {M1_AXI_AWPROT,  M0_AXI_AWPROT};
  assign awvalid = {M1_AXI_AWVALID, M0_AXI_AWVALID};
  assign wdata   = {M1_AXI_WDATA,   M0_AXI_WDATA};
  assign wstrb   = {M1_AXI_WSTRB,   M0_AXI_WSTRB};
  assign wvalid  = {M1_AXI_WVALID,  M0_AXI_WVALID};
  assign bready  = {M1_AXI_BREADY,  M0_AXI_BREADY};
  assign araddr  = {M1_AXI_ARADDR,  M0_AXI_ARADDR};
  assign arprot  = {M1_AXI_ARPROT,  M0_AXI_ARPROT};
  assign arvalid = {M1_AXI_ARVALID, M0_AXI_ARVALID};
  assign rready  = {M1_AXI_RREADY,  M0_AXI_RREADY};

  assign {M1_AXI_AWREADY, M0_AXI_AWREADY} = awready;
  assign {M1_AXI_WREADY,  M0_AXI_WREADY}  = wready;
  assign {M1_AXI_BVALID,  M0_AXI_BVALID}  = bvalid;
  assign {M1_AXI_BRESP,   M0_AXI_BRESP}   = bresp;
  assign {M1_AXI_ARREADY, M0_AXI_ARREADY} = arready;
  assign {M1_AXI_RVALID,  M0_AXI_RVALID}  = rvalid;
  assign {M1_AXI_RRESP,   M0_AXI_RRESP}   = rresp;
  assign {M1_AXI_RDATA,   M0_AXI_RDATA}   = rdata;

  state_t state, state_nx;
  logic   gnt, last_gnt, sel, aw_done, w_done;
  logic   req0, req1, ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign req0  = arvalid[0] | awvalid[0];
  assign req1  = arvalid[1] | awvalid[1];
  // on a tie the master that did not win last time gets the bus
  assign sel   = (req0 & req1) ? ~last_gnt : req1;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID  & S_AXI_RREADY;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID  & S_AXI_BREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 | req1)) begin
        gnt      <= sel;
        last_gnt <= sel;
      end
      if (state == WR_XFER) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (state == WR_RESP && b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 | req1) state_nx = arvalid[sel] ? RD_ADDR : WR_XFER;
      RD_ADDR: if (ar_hs) state_nx = RD_DATA;
      RD_DATA: if (r_hs)  state_nx = IDLE;
      WR_XFER: if ((aw_done | aw_hs) && (w_done | w_hs)) state_nx = WR_RESP;
      WR_RESP: if (b_hs)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWADDR  = '0;  S_AXI_AWPROT = '0;  S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;  S_AXI_WSTRB  = '0;  S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;  S_AXI_ARPROT = '0;  S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    awready = '0;  wready = '0;  bvalid = '0;  bresp = '0;
    arready = '0;  rvalid = '0;  rresp  = '0;  rdata = '0;
    case (state)
      RD_ADDR: begin
        S_AXI_ARADDR  = araddr[gnt];
        S_AXI_ARPROT  = arprot[gnt];
        S_AXI_ARVALID = arvalid[gnt];
        arready[gnt]  = S_AXI_ARREADY;
      end
      RD_DATA: begin
        rdata[gnt]   = S_AXI_RDATA;
        rresp[gnt]   = S_AXI_RRESP;
        rvalid[gnt]  = S_AXI_RVALID;
        S_AXI_RREADY = rready[gnt];
      end
      WR_XFER: begin
        // each channel drops out of the handshake once it has completed
        if (!aw_done) begin
          S_AXI_AWADDR  = awaddr[gnt];
          S_AXI_AWPROT  = awprot[gnt];
          S_AXI_AWVALID = awvalid[gnt];
          awready[gnt]  = S_AXI_AWREADY;
        end
        if (!w_done) begin
          S_AXI_WDATA  = wdata[gnt];
          S_AXI_WSTRB  = wstrb[gnt];
          S_AXI_WVALID = wvalid[gnt];
          wready[gnt]  = S_AXI_WREADY;
        end
      end
      WR_RESP: begin
        bresp[gnt]   = S_AXI_BRESP;
        bvalid[gnt]  = S_AXI_BVALID;
        S_AXI_BREADY = bready[gnt];
      end
      default: ;
    endcase
  end

  assign arb_busy  = (state != IDLE);
  assign arb_grant = arb_busy ? (gnt ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_axi_lite_arb_2to1.sv
// Directed bench for the 2:1 AXI-Lite arbiter: reactive slave with programmable delays,
// responses checked in order against a queue filled when each transaction is issued.
module tb_axi_lite_arb_2to1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [1:0][31:0] m_awaddr, m_wdata, m_araddr;
  logic [1:0][2:0]  m_awprot, m_arprot;
  logic [1:0][3:0]  m_wstrb;
  wire  [1:0]       m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  wire  [1:0][1:0]  m_bresp, m_rresp;
  wire  [1:0][31:0] m_rdata;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [1:0]  arb_grant;
  logic        arb_busy;

  axi_lite_arb_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .M0_AXI_AWADDR(m_awaddr[0]), .M0_AXI_AWPROT(m_awprot[0]), .M0_AXI_AWVALID(m_awvalid[0]),
    .M0_AXI_AWREADY(m_awready[0]), .M0_AXI_WDATA(m_wdata[0]), .M0_AXI_WSTRB(m_wstrb[0]),
    .M0_AXI_WVALID(m_wvalid[0]), .M0_AXI_WREADY(m_wready[0]), .M0_AXI_BRESP(m_bresp[0]),
    .M0_AXI_BVALID(m_bvalid[0]), .M0_AXI_BREADY(m_bready[0]), .M0_AXI_ARADDR(m_araddr[0]),
    .M0_AXI_ARPROT(m_arprot[0]), .M0_AXI_ARVALID(m_arvalid[0]), .M0_AXI_ARREADY(m_arready[0]),
    .M0_AXI_RDATA(m_rdata[0]), .M0_AXI_RRESP(m_rresp[0]), .M0_AXI_RVALID(m_rvalid[0]),
    .M0_AXI_RREADY(m_rready[0]),
    .M1_AXI_AWADDR(m_awaddr[1]), .M1_AXI_AWPROT(m_awprot[1]), .M1_AXI_AWVALID(m_awvalid[1]),
    .M1_AXI_AWREADY(m_awready[1]), .M1_AXI_WDATA(m_wdata[1]), .M1_AXI_WSTRB(m_wstrb[1]),
    .M1_AXI_WVALID(m_wvalid[1]), .M1_AXI_WREADY(m_wready[1]), .M1_AXI_BRESP(m_bresp[1]),
    .M1_AXI_BVALID(m_bvalid[1]), .M1_AXI_BREADY(m_bready[1]), .M1_AXI_ARADDR(m_araddr[1]),
    .M1_AXI_ARPROT(m_arprot[1]), .M1_AXI_ARVALID(m_arvalid[1]), .M1_AXI_ARREADY(m_arready[1]),
    .M1_AXI_RDATA(m_rdata[1]), .M1_AXI_RRESP(m_rresp[1]), .M1_AXI_RVALID(m_rvalid[1]),
    .M1_AXI_RREADY(m_rready[1]),
    .S_AXI_AWADDR(s_awaddr), .S_AXI_AWPROT(s_awprot), .S_AXI_AWVALID(s_awvalid),
    .S_AXI_AWREADY(s_awready), .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb),
    .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready), .S_AXI_BRESP(s_bresp),
    .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready), .S_AXI_ARADDR(s_araddr),
    .S_AXI_ARPROT(s_arprot), .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid),
    .S_AXI_RREADY(s_rready),
    .arb_grant(arb_grant), .arb_busy(arb_busy)
  );

  int checks = 0;
  int errs = 0;
  // scoreboard entry: {is_write, master, data, resp}
  logic [35:0] sb[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic got(input logic [35:0] v);
    checks++;
    assert (sb.size() != 0) else begin
      errs++;
      $error("FAIL unexpected_resp: observed %0h expected none", v);
    end
    if (sb.size() != 0) chk("resp_order", {60'b0, v}, {60'b0, sb.pop_front()});
  endtask

  function automatic logic [31:0] sd(input logic [31:0] a);
    return 32'hDEAD_BEEF ^ a ^ 32'h10;
  endfunction
  function automatic logic [1:0] sr(input logic [31:0] a);
    return a[12] ? 2'b10 : 2'b00;
  endfunction

  // sampled just before each rising edge; drivers act on these at the next falling edge
  logic [1:0]  m_ar_hs = '0, m_aw_hs = '0, m_w_hs = '0, m_r_hs = '0, m_b_hs = '0;
  logic        s_arv_s = 0, s_awv_s = 0, s_wv_s = 0, s_rv_s = 0;
  logic        s_ar_hs = 0, s_aw_hs = 0, s_w_hs = 0, s_r_hs = 0, s_b_hs = 0;
  logic [31:0] s_araddr_s = '0, aw_addr_cap = '0, w_data_cap = '0;
  logic [3:0]  w_strb_cap = '0;
  int cyc = 0, n_saw = 0, n_sw = 0, aw_cyc = 0, w_cyc = 0, rv0_cnt = 0, bv0_cnt = 0, viol = 0;

  always begin
    @(negedge clk);
    #4;
    cyc++;
    s_arv_s = s_arvalid; s_awv_s = s_awvalid; s_wv_s = s_wvalid; s_rv_s = s_rvalid;
    s_araddr_s = s_araddr;
    s_ar_hs = rst_n & s_arvalid & s_arready;
    s_aw_hs = rst_n & s_awvalid & s_awready;
    s_w_hs  = rst_n & s_wvalid & s_wready;
    s_r_hs  = rst_n & s_rvalid & s_rready;
    s_b_hs  = rst_n & s_bvalid & s_bready;
    m_ar_hs = rst_n ? (m_arvalid & m_arready) : 2'b00;
    m_aw_hs = rst_n ? (m_awvalid & m_awready) : 2'b00;
    m_w_hs  = rst_n ? (m_wvalid & m_wready) : 2'b00;
    m_r_hs  = rst_n ? (m_rvalid & m_rready) : 2'b00;
    m_b_hs  = rst_n ? (m_bvalid & m_bready) : 2'b00;
    if (s_aw_hs) begin n_saw++; aw_cyc = cyc; aw_addr_cap = s_awaddr; end
    if (s_w_hs)  begin n_sw++;  w_cyc = cyc;  w_data_cap = s_wdata; w_strb_cap = s_wstrb; end
    if (m_rvalid[0]) rv0_cnt++;
    if (m_bvalid[0]) bv0_cnt++;
    if (m_arready[0] && arb_grant == 2'b10) viol++;
    for (int i = 0; i < 2; i++) begin
      if (m_r_hs[i]) got({1'b0, i[0], m_rdata[i], m_rresp[i]});
      if (m_b_hs[i]) got({1'b1, i[0], 32'h0, m_bresp[i]});
    end
  end

  // reactive slave
  int aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  int aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic rd_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] rd_addr = '0, wr_addr = '0;

  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      s_awready = 0; s_wready = 0; s_arready = 0; s_rvalid = 0; s_bvalid = 0;
      s_rdata = '0; s_rresp = '0; s_bresp = '0;
      rd_pend = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    end else begin
      if (s_ar_hs) begin
        s_arready = 0; rd_pend = 1; r_cnt = r_dly; rd_addr = s_araddr_s;
      end else if (s_arv_s && !rd_pend) s_arready = 1;
      if (s_r_hs) begin
        s_rvalid = 0; s_rdata = '0; s_rresp = '0; rd_pend = 0;
      end else if (rd_pend && !s_rvalid) begin
        if (r_cnt == 0) begin s_rvalid = 1; s_rdata = sd(rd_addr); s_rresp = sr(rd_addr); end
        else r_cnt--;
      end
      if (s_aw_hs) begin
        s_awready = 0; aw_got = 1; wr_addr = aw_addr_cap;
      end else if (s_awv_s && !aw_got) begin
        if (aw_cnt >= aw_dly) s_awready = 1; else aw_cnt++;
      end
      if (s_w_hs) begin
        s_wready = 0; w_got = 1;
      end else if (s_wv_s && !w_got) begin
        if (w_cnt >= w_dly) s_wready = 1; else w_cnt++;
      end
      if (s_b_hs) begin
        s_bvalid = 0; s_bresp = '0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (aw_got && w_got && !s_bvalid) begin
        if (b_cnt >= b_dly) begin s_bvalid = 1; s_bresp = sr(wr_addr); end
        else b_cnt++;
      end
    end
  end

  // k: 0 AR, 1 AW, 2 W, 3 R, 4 B handshake of master i; 5 slave RVALID pending
  task automatic wait_hs(input int k, input int i, input string tag);
    int n = 0;
    logic f = 0;
    while (!f && n < 200) begin
      @(negedge clk);
      n++;
      case (k)
        0: f = m_ar_hs[i];
        1: f = m_aw_hs[i];
        2: f = m_w_hs[i];
        3: f = m_r_hs[i];
        4: f = m_b_hs[i];
        default: f = s_rv_s;
      endcase
    end
    chk({tag, "_wait"}, {95'b0, f}, 96'd1);
  endtask

  task automatic rd(input int i, input logic [31:0] a);
    @(negedge clk);
    m_arvalid[i] = 1; m_araddr[i] = a;
    wait_hs(0, i, "ar");
    m_arvalid[i] = 0; m_araddr[i] = '0;
    wait_hs(3, i, "r");
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    m_awvalid[i] = 1; m_awaddr[i] = a; m_wvalid[i] = 1; m_wdata[i] = d; m_wstrb[i] = s;
    while ((m_awvalid[i] || m_wvalid[i]) && n < 200) begin
      @(negedge clk);
      n++;
      if (m_aw_hs[i]) begin m_awvalid[i] = 0; m_awaddr[i] = '0; end
      if (m_w_hs[i])  begin m_wvalid[i] = 0; m_wdata[i] = '0; m_wstrb[i] = '0; end
    end
    chk("aw_w_wait", {94'b0, m_awvalid[i], m_wvalid[i]}, 96'd0);
    wait_hs(4, i, "b");
  endtask

  function automatic logic [95:0] idle_outs();
    return {78'b0, arb_grant, arb_busy, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
            m_arready, m_awready, m_wready, m_rvalid, m_bvalid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = 2'b11; m_rready = 2'b11;
    m_awaddr = '0; m_wdata = '0; m_araddr = '0; m_awprot = '0; m_arprot = '0; m_wstrb = '0;

    // reset state
    repeat (3) @(negedge clk);
    #4 chk("reset_outs", idle_outs(), 96'd0);
    @(negedge clk); rst_n = 1;

    // single M0 read, grant visible one cycle after the request
    @(negedge clk);
    m_arvalid[0] = 1; m_araddr[0] = 32'h0000_0010;
    sb.push_back({1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00});
    #4 chk("t1_pre_grant", {93'b0, s_arvalid, arb_grant}, 96'b000);
    @(negedge clk);
    #4 chk("t1_grant", {93'b0, s_arvalid, arb_grant}, 96'b101);
    wait_hs(0, 0, "t1_ar");
    m_arvalid[0] = 0; m_araddr[0] = '0;
    wait_hs(3, 0, "t1_r");
    #4 chk("t1_grant_idle", {94'b0, arb_grant}, 96'b00);

    // fresh reset, then two ties with a lone M0 read in between
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    sb.push_back({1'b0, 1'b0, sd(32'h20), 2'b00});
    sb.push_back({1'b0, 1'b1, sd(32'h30), 2'b00});
    fork rd(0, 32'h20); rd(1, 32'h30); join
    sb.push_back({1'b0, 1'b0, sd(32'h40), 2'b00});
    rd(0, 32'h40);
    sb.push_back({1'b0, 1'b1, sd(32'h50), 2'b00});
    sb.push_back({1'b0, 1'b0, sd(32'h60), 2'b00});
    fork rd(0, 32'h60); rd(1, 32'h50); join

    // M1 write, slave W accepted two cycles before AW
    aw_dly = 2; b0 = n_saw; b1 = n_sw; bv0_cnt = 0;
    sb.push_back({1'b1, 1'b1, 32'h0, 2'b00});
    wr(1, 32'h0000_0100, 32'h1234_5678, 4'hF);
    chk("t3_aw_count", 96'(n_saw - b0), 96'd1);
    chk("t3_w_count", 96'(n_sw - b1), 96'd1);
    chk("t3_w_before_aw", 96'(aw_cyc - w_cyc), 96'd2);
    chk("t3_payload", {28'b0, aw_addr_cap, w_data_cap, w_strb_cap}, {28'b0, 32'h100, 32'h1234_5678, 4'hF});
    chk("t3_m0_bvalid", 96'(bv0_cnt), 96'd0);
    aw_dly = 0;

    // M1 AR and AW together: read first, write afterwards; error codes pass through
    sb.push_back({1'b0, 1'b1, sd(32'h1000), 2'b10});
    sb.push_back({1'b1, 1'b1, 32'h0, 2'b10});
    fork rd(1, 32'h1000); wr(1, 32'h1100, 32'hA5A5_0001, 4'h3); join

    // M0 read raised while M1 waits on a slow B response
    b_dly = 5; viol = 0;
    sb.push_back({1'b1, 1'b1, 32'h0, 2'b00});
    sb.push_back({1'b0, 1'b0, sd(32'h300), 2'b00});
    fork
      wr(1, 32'h200, 32'h0BAD_F00D, 4'hF);
      begin repeat (3) @(negedge clk); rd(0, 32'h300); end
    join
    chk("t5_no_early_arready", 96'(viol), 96'd0);
    b_dly = 0;

    // reset while read data is pending on the slave
    r_dly = 3; m_rready[0] = 0;
    @(negedge clk); m_arvalid[0] = 1; m_araddr[0] = 32'h400;
    wait_hs(0, 0, "t6_ar");
    m_arvalid[0] = 0; m_araddr[0] = '0;
    wait_hs(5, 0, "t6_rvalid");
    rst_n = 0; m_rready[0] = 1;
    #4 chk("t6_reset_outs", idle_outs(), 96'd0);
    @(negedge clk); @(negedge clk); rst_n = 1; rv0_cnt = 0;
    repeat (8) @(negedge clk);
    chk("t6_no_replay", 96'(rv0_cnt), 96'd0);
    #4 chk("t6_idle", idle_outs(), 96'd0);
    r_dly = 0;

    chk("sb_empty", 96'(sb.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule

// File: doc/axi_lite_arb_2to1.md
AXI_LITE_ARB_2TO1 -- requirements
Module: axi_lite_arb_2to1

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all AW/AR channels.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all W/R channels; WSTRB width DATA_WIDTH/8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 M0_AXI_* AXI4-Lite slave port, master 0 (instruction fetch): AW, W, B, AR and R channels with AWADDR/ARADDR ADDR_WIDTH, AWPROT/ARPROT 3, WDATA/RDATA DATA_WIDTH, WSTRB DATA_WIDTH/8, BRESP/RRESP 2, VALID/READY 1; standard directions.
REQ-006 M1_AXI_*  same set as M0, master 1 (load/store unit).
REQ-007 S_AXI_*  AXI4-Lite master port to shared memory slave, same channel set, opposite directions.
REQ-008 arb_grant  output  2  one-hot current grant (bit0 = M0, bit1 = M1); 2'b00 when idle.
REQ-009 arb_busy  output  1  high while any transaction is granted.

Function
REQ-010 States: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP; one transaction outstanding at a time.
REQ-011 Request of master i: ARVALID_i | AWVALID_i, sampled only in IDLE.
REQ-012 Single requester: granted. Both requesting: grant master != last_gnt (round-robin); last_gnt updated on every grant.
REQ-013 Within one granted master, pending AR takes precedence over pending AW: IDLE -> RD_ADDR; AW only: IDLE -> WR_XFER.
REQ-014 Grant registered: S-side VALID first asserted the cycle after IDLE sees the request (1-cycle arbitration latency).
REQ-015 RD_ADDR: S_ARADDR/ARPROT/ARVALID = granted master's; granted ARREADY = S_ARREADY; on S_ARVALID & S_ARREADY -> RD_DATA.
REQ-016 RD_DATA: S_RDATA/RRESP/RVALID routed to granted master; S_RREADY = granted RREADY; on R handshake -> IDLE.
REQ-017 WR_XFER: AW and W forwarded independently; flags aw_done/w_done set on respective handshakes; S_AWVALID masked once aw_done, S_WVALID masked once w_done; both done (same or different cycles) -> WR_RESP.
REQ-018 WR_RESP: S_BRESP/BVALID routed to granted master; S_BREADY = granted BREADY; on B handshake -> IDLE, flags cleared.
REQ-019 Non-granted master: AWREADY, WREADY, ARREADY, BVALID, RVALID held 0; its RDATA/RRESP/BRESP driven 0.
REQ-020 IDLE: all S-side VALID and READY 0; S address/data/strobe/prot driven 0.
REQ-021 No address/data latched: forwarding is combinational from granted master; masters hold VALID and payload per AXI until handshake.
REQ-022 Minimum one IDLE cycle between consecutive transactions; M1 waits at most one transaction when M0 requests continuously.
REQ-023 Response codes passed through unmodified; arbiter generates no error responses.
REQ-024 No combinational path from any M-side VALID to any M-side READY of the same master except via S-side READY.

Reset
REQ-025 While rst_n low: state IDLE, aw_done = w_done = 0, last_gnt = M1 (so M0 wins first tie), arb_grant = 0, arb_busy = 0, all VALID/READY outputs 0.
REQ-026 Reset asserted mid-transaction aborts it immediately; no pending response is replayed after release.
REQ-027 First grant possible on the first rising edge after rst_n deasserts.

Verification
REQ-028 M0 ARVALID, ARADDR 0x0000_0010 alone; slave ARREADY/RVALID 1 cycle each, RDATA 0xDEAD_BEEF -> S_ARVALID cycle 1 after request, M0 receives 0xDEAD_BEEF RRESP 0, arb_grant 01 then 00.
REQ-029 M0 AR and M1 AR asserted same cycle after reset -> M0 served first, M1 next; repeat simultaneous -> order alternates (M1 then M0).
REQ-030 M1 write 0x0000_0100, WDATA 0x1234_5678, WSTRB 0xF; slave WREADY 2 cycles before AWREADY -> single AW and single W handshake on S, BRESP 0 to M1 only, M0 BVALID never high.
REQ-031 M1 asserts ARVALID and AWVALID together -> read completes first, write granted in a later IDLE arbitration.
REQ-032 rst_n low during RD_DATA with slave RVALID pending -> all outputs 0 within reset, state IDLE, M0 sees no RVALID after release.
REQ-033 Slave BVALID delayed 5 cycles, M0 AR raised meanwhile -> M0 ARREADY stays 0 until B handshake to M1, then granted.
